// File: rtl/id_stage_pipelined_pkg.sv
//==============================================================================
// Module      : id_pkg
// Description : Shared decode types, EXE command codes and the legacy
//               ControlUnit / ConditionCheck decode functions.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

package id_pkg;

  typedef struct packed {
    logic       s;
    logic       b;
    logic [3:0] exe_cmd;
    logic       mem_w;
    logic       mem_r;
    logic       wb_en;
  } ctrl_t;

  localparam logic [3:0] EXE_NOP = 4'b0000;
  localparam logic [3:0] EXE_MOV = 4'b0001;
  localparam logic [3:0] EXE_ADD = 4'b0010;
  localparam logic [3:0] EXE_ADC = 4'b0011;
  localparam logic [3:0] EXE_SUB = 4'b0100;
  localparam logic [3:0] EXE_SBC = 4'b0101;
  localparam logic [3:0] EXE_AND = 4'b0110;
  localparam logic [3:0] EXE_ORR = 4'b0111;
  localparam logic [3:0] EXE_EOR = 4'b1000;
  localparam logic [3:0] EXE_MVN = 4'b1001;

  localparam logic [1:0] ARITH  = 2'b00;
  localparam logic [1:0] MEM    = 2'b01;
  localparam logic [1:0] BRANCH = 2'b10;

  // Fixed-width part of the ID/EX register; datapath-wide fields live beside it.
  typedef struct packed {
    logic        valid;
    ctrl_t       ctrl;
    logic        imm;
    logic [11:0] shift_op;
    logic [23:0] simm24;
  } id_ex_t;

  function automatic ctrl_t control_unit(input logic [1:0] mode,
                                         input logic [3:0] opcode,
                                         input logic       s_in);
    ctrl_t c;
    c = '0;
    case (mode)
      ARITH: begin
        c.s     = s_in;
        c.wb_en = 1'b1;
        case (opcode)
          4'b1101: c.exe_cmd = EXE_MOV;
          4'b1111: c.exe_cmd = EXE_MVN;
          4'b0100: c.exe_cmd = EXE_ADD;
          4'b0101: c.exe_cmd = EXE_ADC;
          4'b0010: c.exe_cmd = EXE_SUB;
          4'b0110: c.exe_cmd = EXE_SBC;
          4'b0000: c.exe_cmd = EXE_AND;
          4'b1100: c.exe_cmd = EXE_ORR;
          4'b0001: c.exe_cmd = EXE_EOR;
          4'b1010: begin c.exe_cmd = EXE_SUB; c.wb_en = 1'b0; end
          4'b1000: begin c.exe_cmd = EXE_AND; c.wb_en = 1'b0; end
          default: c = '0;
        endcase
      end
      MEM: begin
        c.exe_cmd = EXE_ADD;
        c.mem_r   = s_in;
        c.wb_en   = s_in;
        c.mem_w   = ~s_in;
      end
      BRANCH:  c.b = 1'b1;
      default: c = '0;
    endcase
    return c;
  endfunction

  // status = {N, Z, C, V}
  function automatic logic cond_check(input logic [3:0] cond, input logic [3:0] status);
    logic n, z, c, v;
    {n, z, c, v} = status;
    case (cond)
      4'h0:    return z;
      4'h1:    return ~z;
      4'h2:    return c;
      4'h3:    return ~c;
      4'h4:    return n;
      4'h5:    return ~n;
      4'h6:    return v;
      4'h7:    return ~v;
      4'h8:    return c & ~z;
      4'h9:    return ~c | z;
      4'hA:    return n == v;
      4'hB:    return n != v;
      4'hC:    return ~z & (n == v);
      4'hD:    return z | (n != v);
      4'hE:    return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

endpackage

`default_nettype wire

// File: rtl/id_stage_pipelined_if.sv
//==============================================================================
// Module      : id_stage_pipelined_if
// Description : IF/ID, write-back, control and ID/EX signals of the decode stage.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

interface id_stage_pipelined_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 4,
  parameter int CTRL_W = 9,
  parameter int CNT_W  = 16
);
  logic [DATA_W-1:0] PC_in;
  logic [31:0]       Instruction;
  logic              in_valid;
  logic [DATA_W-1:0] Result_WB;
  logic              writeBackEn;
  logic [ADDR_W-1:0] Dest_wb;
  logic [3:0]        Status;
  logic              hazard;
  logic              hold;
  logic              flush;
  logic [ADDR_W-1:0] src1;
  logic [ADDR_W-1:0] src2;
  logic              two_src;
  logic              ex_valid;
  logic [CTRL_W-1:0] ex_ctrl;
  logic [DATA_W-1:0] ex_PC;
  logic [DATA_W-1:0] ex_Val_Rn;
  logic [DATA_W-1:0] ex_Val_Rm;
  logic              ex_imm;
  logic [11:0]       ex_shift_op;
  logic [23:0]       ex_simm24;
  logic [ADDR_W-1:0] ex_Dest;
  logic [ADDR_W-1:0] ex_src1;
  logic [ADDR_W-1:0] ex_src2;
  logic [CNT_W-1:0]  bubble_cnt;

  modport master (
    output PC_in, Instruction, in_valid, Result_WB, writeBackEn, Dest_wb,
           Status, hazard, hold, flush,
    input  src1, src2, two_src, ex_valid, ex_ctrl, ex_PC, ex_Val_Rn, ex_Val_Rm,
           ex_imm, ex_shift_op, ex_simm24, ex_Dest, ex_src1, ex_src2, bubble_cnt
  );

  modport slave (
    input  PC_in, Instruction, in_valid, Result_WB, writeBackEn, Dest_wb,
           Status, hazard, hold, flush,
    output src1, src2, two_src, ex_valid, ex_ctrl, ex_PC, ex_Val_Rn, ex_Val_Rm,
           ex_imm, ex_shift_op, ex_simm24, ex_Dest, ex_src1, ex_src2, bubble_cnt
  );
endinterface

`default_nettype wire

// File: rtl/id_stage_pipelined_regfile_bypass.sv
//==============================================================================
// Module      : regfile_bypass
// Description : Two-read/one-write register file, optional same-cycle WB bypass;
//               out-of-range reads return the PC.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module regfile_bypass #(
  parameter int DATA_W    = 32,
  parameter int NUM_REGS  = 15,
  parameter int ADDR_W    = 4,
  parameter int BYPASS_EN = 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   we,
  input  logic [ADDR_W-1:0]      waddr,
  input  logic [DATA_W-1:0]      wdata,
  input  logic [1:0][ADDR_W-1:0] raddr,
  input  logic [DATA_W-1:0]      pc,
  output logic [1:0][DATA_W-1:0] rdata
);

  localparam logic [ADDR_W:0] c_num_regs = NUM_REGS[ADDR_W:0];

  logic [DATA_W-1:0] r_regs [NUM_REGS];
  logic              w_wr_ok;

  assign w_wr_ok = we && ({1'b0, waddr} < c_num_regs);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_REGS; i++) r_regs[i] <= '0;
    end else if (w_wr_ok) begin
      r_regs[waddr] <= wdata;
    end
  end

  for (genvar p = 0; p < 2; p++) begin : g_rd
    logic w_in_range;
    logic w_hit;

    assign w_in_range = {1'b0, raddr[p]} < c_num_regs;
    assign w_hit      = (BYPASS_EN != 0) && w_wr_ok && (raddr[p] == waddr);

    always_comb begin
      rdata[p] = pc;
      if (w_in_range) rdata[p] = w_hit ? wdata : r_regs[raddr[p]];
    end
  end

endmodule

`default_nettype wire

// File: rtl/id_stage_pipelined.sv
//==============================================================================
// Module      : id_stage_pipelined
// Description : Decode, register file read and ID/EX register with bubble,
//               hold and flush control plus a saturating bubble counter.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module id_stage_pipelined
  import id_pkg::*;
#(
  parameter int DATA_W    = 32,
  parameter int NUM_REGS  = 15,
  parameter int ADDR_W    = 4,
  parameter int CTRL_W    = 9,
  parameter int BYPASS_EN = 1,
  parameter int CNT_W     = 16
) (
  input logic                 clk,
  input logic                 rst,
  id_stage_pipelined_if.slave bus
);

  logic [31:0]              w_ins;
  ctrl_t                    w_dec;
  logic                     w_cond_pass;
  logic [ADDR_W-1:0]        w_src1;
  logic [ADDR_W-1:0]        w_src2;
  logic [1:0][DATA_W-1:0]   w_rdata;
  id_ex_t                   w_next;
  logic                     w_load;
  logic                     w_count;

  id_ex_t                   r_ex;
  logic [DATA_W-1:0]        r_pc;
  logic [DATA_W-1:0]        r_val_rn;
  logic [DATA_W-1:0]        r_val_rm;
  logic [ADDR_W-1:0]        r_dest;
  logic [ADDR_W-1:0]        r_src1;
  logic [ADDR_W-1:0]        r_src2;
  logic [CNT_W-1:0]         r_bubble_cnt;

  assign w_ins       = bus.Instruction;
  assign w_dec       = control_unit(w_ins[27:26], w_ins[24:21], w_ins[20]);
  assign w_cond_pass = cond_check(w_ins[31:28], bus.Status);
  assign w_src1      = ADDR_W'(w_ins[19:16]);
  assign w_src2      = w_dec.mem_w ? ADDR_W'(w_ins[15:12]) : ADDR_W'(w_ins[3:0]);

  regfile_bypass #(
    .DATA_W    (DATA_W),
    .NUM_REGS  (NUM_REGS),
    .ADDR_W    (ADDR_W),
    .BYPASS_EN (BYPASS_EN)
  ) u_regfile (
    .clk   (clk),
    .rst   (rst),
    .we    (bus.writeBackEn),
    .waddr (bus.Dest_wb),
    .wdata (bus.Result_WB),
    .raddr ({w_src2, w_src1}),
    .pc    (bus.PC_in),
    .rdata (w_rdata)
  );

  // Flush and hazard both force a dead slot; ctrl also dies on a failed condition.
  always_comb begin
    w_next          = '0;
    w_next.valid    = ~bus.flush & ~bus.hazard & bus.in_valid & w_cond_pass;
    w_next.ctrl     = w_next.valid ? w_dec : '0;
    w_next.imm      = w_ins[25];
    w_next.shift_op = w_ins[11:0];
    w_next.simm24   = w_ins[23:0];
  end

  assign w_load  = bus.flush | ~bus.hold;
  assign w_count = ~bus.flush & ~bus.hold & bus.hazard & (r_bubble_cnt != '1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ex         <= '0;
      r_pc         <= '0;
      r_val_rn     <= '0;
      r_val_rm     <= '0;
      r_dest       <= '0;
      r_src1       <= '0;
      r_src2       <= '0;
      r_bubble_cnt <= '0;
    end else begin
      if (w_load) begin
        r_ex     <= w_next;
        r_pc     <= bus.PC_in;
        r_val_rn <= w_rdata[0];
        r_val_rm <= w_rdata[1];
        r_dest   <= ADDR_W'(w_ins[15:12]);
        r_src1   <= w_src1;
        r_src2   <= w_src2;
      end
      if (w_count) r_bubble_cnt <= r_bubble_cnt + 1'b1;
    end
  end

  assign bus.src1        = w_src1;
  assign bus.src2        = w_src2;
  assign bus.two_src     = w_dec.mem_w | ~w_ins[25];
  assign bus.ex_valid    = r_ex.valid;
  assign bus.ex_ctrl     = CTRL_W'(r_ex.ctrl);
  assign bus.ex_PC       = r_pc;
  assign bus.ex_Val_Rn   = r_val_rn;
  assign bus.ex_Val_Rm   = r_val_rm;
  assign bus.ex_imm      = r_ex.imm;
  assign bus.ex_shift_op = r_ex.shift_op;
  assign bus.ex_simm24   = r_ex.simm24;
  assign bus.ex_Dest     = r_dest;
  assign bus.ex_src1     = r_src1;
  assign bus.ex_src2     = r_src2;
  assign bus.bubble_cnt  = r_bubble_cnt;

endmodule

`default_nettype wire

// File: tb/tb_id_stage_pipelined.sv
//==============================================================================
// Module      : tb_id_stage_pipelined
// Description : Directed vector table plus hand sequences for stall, flush,
//               async reset and counter saturation.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_id_stage_pipelined;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  id_stage_pipelined_if #(.DATA_W(32), .ADDR_W(4), .CTRL_W(9), .CNT_W(16)) bus ();
  id_stage_pipelined_if #(.DATA_W(32), .ADDR_W(4), .CTRL_W(9), .CNT_W(16)) bus_nb ();

  id_stage_pipelined #(.DATA_W(32), .NUM_REGS(15), .ADDR_W(4), .CTRL_W(9),
                       .BYPASS_EN(1), .CNT_W(16))
    dut (.clk(clk), .rst(rst), .bus(bus));

  id_stage_pipelined #(.DATA_W(32), .NUM_REGS(15), .ADDR_W(4), .CTRL_W(9),
                       .BYPASS_EN(0), .CNT_W(16))
    dut_nb (.clk(clk), .rst(rst), .bus(bus_nb));

  // Second instance sees identical stimulus; only its bypass setting differs.
  assign bus_nb.PC_in       = bus.PC_in;
  assign bus_nb.Instruction = bus.Instruction;
  assign bus_nb.in_valid    = bus.in_valid;
  assign bus_nb.Result_WB   = bus.Result_WB;
  assign bus_nb.writeBackEn = bus.writeBackEn;
  assign bus_nb.Dest_wb     = bus.Dest_wb;
  assign bus_nb.Status      = bus.Status;
  assign bus_nb.hazard      = bus.hazard;
  assign bus_nb.hold        = bus.hold;
  assign bus_nb.flush       = bus.flush;

  typedef struct {
    logic [31:0] instr;
    logic [31:0] pc;
    logic [3:0]  status;
    logic        in_valid;
    logic        wb_en;
    logic [3:0]  dest_wb;
    logic [31:0] result_wb;
    logic [3:0]  e_src1;
    logic [3:0]  e_src2;
    logic        e_two;
    logic        e_valid;
    logic [8:0]  e_ctrl;
    logic [31:0] e_rn;
    logic [31:0] e_rm;
    logic [31:0] e_nb_rn;
    logic [3:0]  e_dest;
  } vec_t;

  localparam logic [31:0] ADD_R1_R3_R2 = 32'hE083_1002;
  localparam logic [31:0] CMP_R3_R2    = 32'hE153_0002;

  int   total = 0;
  int   bad   = 0;
  vec_t vecs [13];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [31:0] instr, input logic [31:0] pc, input logic iv,
                       input logic hz, input logic hd, input logic fl);
    bus.Instruction = instr;
    bus.PC_in       = pc;
    bus.Status      = 4'b0000;
    bus.in_valid    = iv;
    bus.hazard      = hz;
    bus.hold        = hd;
    bus.flush       = fl;
    bus.writeBackEn = 1'b0;
    bus.Dest_wb     = 4'd0;
    bus.Result_WB   = 32'd0;
  endtask

  initial begin
    //                instr         pc        st     iv wb dwb    res          s1   s2   two v  ctrl    rn           rm           nb_rn        dest
    vecs[0]  = '{32'h0000_0000, 32'h00, 4'b0000, 0, 1, 4'd3,  32'hAA,     4'd0,4'd0,1, 0, 9'h000, 32'h0,       32'h0,       32'h0,       4'd0};
    vecs[1]  = '{32'h0000_0000, 32'h00, 4'b0000, 0, 1, 4'd2,  32'h22,     4'd0,4'd0,1, 0, 9'h000, 32'h0,       32'h0,       32'h0,       4'd0};
    vecs[2]  = '{ADD_R1_R3_R2,  32'h40, 4'b0000, 1, 1, 4'd7,  32'h77,     4'd3,4'd2,1, 1, 9'h011, 32'hAA,      32'h22,      32'hAA,      4'd1};
    vecs[3]  = '{32'hE085_4003, 32'h44, 4'b0000, 1, 1, 4'd5,  32'h1234,   4'd5,4'd3,1, 1, 9'h011, 32'h1234,    32'hAA,      32'h0,       4'd4};
    vecs[4]  = '{32'hE482_7000, 32'h48, 4'b0000, 1, 0, 4'd0,  32'h0,      4'd2,4'd7,1, 1, 9'h014, 32'h22,      32'h77,      32'h22,      4'd7};
    vecs[5]  = '{32'h0083_1002, 32'h4C, 4'b0000, 1, 0, 4'd0,  32'h0,      4'd3,4'd2,1, 0, 9'h000, 32'hAA,      32'h22,      32'hAA,      4'd1};
    vecs[6]  = '{32'h0083_1002, 32'h50, 4'b0100, 1, 0, 4'd0,  32'h0,      4'd3,4'd2,1, 1, 9'h011, 32'hAA,      32'h22,      32'hAA,      4'd1};
    vecs[7]  = '{32'hE493_8000, 32'h54, 4'b0000, 1, 0, 4'd0,  32'h0,      4'd3,4'd0,1, 1, 9'h013, 32'hAA,      32'h0,       32'hAA,      4'd8};
    vecs[8]  = '{32'hE3B0_9005, 32'h58, 4'b0000, 1, 0, 4'd0,  32'h0,      4'd0,4'd5,0, 1, 9'h109, 32'h0,       32'h1234,    32'h0,       4'd9};
    vecs[9]  = '{32'hEA00_0010, 32'h5C, 4'b0000, 1, 0, 4'd0,  32'h0,      4'd0,4'd0,0, 1, 9'h080, 32'h0,       32'h0,       32'h0,       4'd0};
    vecs[10] = '{32'hE08F_1003, 32'h100,4'b0000, 1, 1, 4'd15, 32'hDEAD,   4'd15,4'd3,1,1, 9'h011, 32'h100,     32'hAA,      32'h100,     4'd1};
    vecs[11] = '{ADD_R1_R3_R2,  32'h64, 4'b0000, 0, 0, 4'd0,  32'h0,      4'd3,4'd2,1, 0, 9'h000, 32'hAA,      32'h22,      32'hAA,      4'd1};
    vecs[12] = '{CMP_R3_R2,     32'h68, 4'b0000, 1, 0, 4'd0,  32'h0,      4'd3,4'd2,1, 1, 9'h120, 32'hAA,      32'h22,      32'hAA,      4'd0};

    drive(32'd0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    #12;
    chk("rst.ex_valid", bus.ex_valid, 0);
    chk("rst.ex_ctrl", bus.ex_ctrl, 0);
    chk("rst.ex_Val_Rn", bus.ex_Val_Rn, 0);
    chk("rst.ex_PC", bus.ex_PC, 0);
    chk("rst.bubble_cnt", bus.bubble_cnt, 0);
    rst = 1'b0;
    tick();

    for (int i = 0; i < 13; i++) begin
      drive(vecs[i].instr, vecs[i].pc, vecs[i].in_valid, 1'b0, 1'b0, 1'b0);
      bus.Status      = vecs[i].status;
      bus.writeBackEn = vecs[i].wb_en;
      bus.Dest_wb     = vecs[i].dest_wb;
      bus.Result_WB   = vecs[i].result_wb;
      #1;
      chk($sformatf("v%0d.src1", i), bus.src1, vecs[i].e_src1);
      chk($sformatf("v%0d.src2", i), bus.src2, vecs[i].e_src2);
      chk($sformatf("v%0d.two_src", i), bus.two_src, vecs[i].e_two);
      @(posedge clk);
      #1;
      chk($sformatf("v%0d.ex_valid", i), bus.ex_valid, vecs[i].e_valid);
      chk($sformatf("v%0d.ex_ctrl", i), bus.ex_ctrl, vecs[i].e_ctrl);
      chk($sformatf("v%0d.ex_Val_Rn", i), bus.ex_Val_Rn, vecs[i].e_rn);
      chk($sformatf("v%0d.ex_Val_Rm", i), bus.ex_Val_Rm, vecs[i].e_rm);
      chk($sformatf("v%0d.nb_Val_Rn", i), bus_nb.ex_Val_Rn, vecs[i].e_nb_rn);
      chk($sformatf("v%0d.ex_Dest", i), bus.ex_Dest, vecs[i].e_dest);
      chk($sformatf("v%0d.ex_src1", i), bus.ex_src1, vecs[i].e_src1);
      chk($sformatf("v%0d.ex_src2", i), bus.ex_src2, vecs[i].e_src2);
      chk($sformatf("v%0d.ex_PC", i), bus.ex_PC, vecs[i].pc);
      chk($sformatf("v%0d.ex_imm", i), bus.ex_imm, vecs[i].instr[25]);
      chk($sformatf("v%0d.ex_shift_op", i), bus.ex_shift_op, vecs[i].instr[11:0]);
      chk($sformatf("v%0d.ex_simm24", i), bus.ex_simm24, vecs[i].instr[23:0]);
      chk($sformatf("v%0d.bubble_cnt", i), bus.bubble_cnt, 0);
    end

    // Three hazard bubbles
    drive(ADD_R1_R3_R2, 32'h40, 1'b1, 1'b1, 1'b0, 1'b0);
    for (int k = 1; k <= 3; k++) begin
      tick();
      chk($sformatf("hz%0d.ex_valid", k), bus.ex_valid, 0);
      chk($sformatf("hz%0d.ex_ctrl", k), bus.ex_ctrl, 0);
      chk($sformatf("hz%0d.bubble_cnt", k), bus.bubble_cnt, k);
    end
    drive(ADD_R1_R3_R2, 32'h40, 1'b1, 1'b0, 1'b0, 1'b0);
    tick();
    chk("live.ex_valid", bus.ex_valid, 1);
    chk("live.ex_ctrl", bus.ex_ctrl, 9'h011);

    // hazard together with hold: frozen, no count
    drive(CMP_R3_R2, 32'h80, 1'b1, 1'b1, 1'b1, 1'b0);
    tick();
    chk("hzhold.ex_valid", bus.ex_valid, 1);
    chk("hzhold.ex_ctrl", bus.ex_ctrl, 9'h011);
    chk("hzhold.ex_PC", bus.ex_PC, 32'h40);
    chk("hzhold.ex_Dest", bus.ex_Dest, 4'd1);
    chk("hzhold.bubble_cnt", bus.bubble_cnt, 3);

    // flush overrides hold; flush with hazard is not counted
    drive(ADD_R1_R3_R2, 32'h40, 1'b1, 1'b0, 1'b1, 1'b1);
    tick();
    chk("flhold.ex_valid", bus.ex_valid, 0);
    chk("flhold.ex_ctrl", bus.ex_ctrl, 0);
    drive(ADD_R1_R3_R2, 32'h40, 1'b1, 1'b1, 1'b0, 1'b1);
    tick();
    chk("flhz.ex_valid", bus.ex_valid, 0);
    chk("flhz.bubble_cnt", bus.bubble_cnt, 3);

    // Asynchronous reset between edges
    drive(ADD_R1_R3_R2, 32'h40, 1'b1, 1'b0, 1'b0, 1'b0);
    tick();
    chk("pre_arst.ex_valid", bus.ex_valid, 1);
    #3 rst = 1'b1;
    #1;
    chk("arst.ex_valid", bus.ex_valid, 0);
    chk("arst.ex_ctrl", bus.ex_ctrl, 0);
    chk("arst.ex_Val_Rn", bus.ex_Val_Rn, 0);
    chk("arst.ex_PC", bus.ex_PC, 0);
    chk("arst.bubble_cnt", bus.bubble_cnt, 0);
    #1 rst = 1'b0;
    tick();
    chk("post_arst.ex_valid", bus.ex_valid, 1);
    chk("post_arst.ex_Val_Rn", bus.ex_Val_Rn, 0);
    chk("post_arst.ex_Val_Rm", bus.ex_Val_Rm, 0);

    // Saturation of the bubble counter
    drive(ADD_R1_R3_R2, 32'h40, 1'b1, 1'b1, 1'b0, 1'b0);
    repeat (65534) @(posedge clk);
    #1;
    chk("sat.cnt_fffe", bus.bubble_cnt, 16'hFFFE);
    tick();
    chk("sat.cnt_ffff", bus.bubble_cnt, 16'hFFFF);
    tick();
    chk("sat.cnt_hold", bus.bubble_cnt, 16'hFFFF);
    chk("sat.ex_valid", bus.ex_valid, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
